trap_peak_detector: RTL

Downstream consumer of the trapezoidal shaping filter: takes the filter's signed output stream (one sample per clock) and extracts one event per pulse. For each pulse it reports the peak amplitude, the timestamp of the peak and the over-threshold width, followed by a programmable dead time. Its event strobe feeds the readout/histogramming logic.

---
 rtl/package_settings.sv | 4 +
 rtl/peak_detector_pkg.sv | 12 +
 rtl/trap_timestamp_counter.sv | 19 +
 rtl/trap_peak_detector.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/package_settings.sv
// rtl/package_settings.sv - shared datapath widths for the shaping chain
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/peak_detector_pkg.sv
// rtl/peak_detector_pkg.sv - peak detector state encoding and output widths
package peak_detector_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DEAD   = 2'd2,
    REJECT = 2'd3
  } peak_state_e;

  localparam int PEAK_WIDTH_W   = 8;
  localparam int PILEUP_COUNT_W = 16;
endpackage

// File: rtl/trap_timestamp_counter.sv
// rtl/trap_timestamp_counter.sv - free-running wrapping timestamp counter
module trap_timestamp_counter #(
  parameter int TS_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic [TS_WIDTH-1:0] count_o
);

  logic [TS_WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_q + TS_WIDTH'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/trap_peak_detector.sv
// rtl/trap_peak_detector.sv - per-pulse peak/time/width extraction with dead time
// Optional pile-up rejection of over-long pulses: PEAK_PILEUP_REJECT_EN.
module trap_peak_detector
  import package_settings::*;
  import peak_detector_pkg::*;
#(
  parameter int THRESHOLD = 100,
  parameter int HOLDOFF   = 4,
  parameter int MAX_WIDTH = 16,
  parameter int TS_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  output logic                               peak_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amp,
  output logic        [TS_WIDTH-1:0]         peak_time,
  output logic        [PEAK_WIDTH_W-1:0]     peak_width,
  output logic                               busy,
  output logic        [PILEUP_COUNT_W-1:0]   pileup_count
);

  localparam logic signed [SIZE_FILTER_DATA-1:0] THR_S = SIZE_FILTER_DATA'(THRESHOLD);
  localparam logic [PEAK_WIDTH_W-1:0] MAX_W     = PEAK_WIDTH_W'(MAX_WIDTH);
  localparam logic [PEAK_WIDTH_W-1:0] DEAD_LOAD = PEAK_WIDTH_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic [TS_WIDTH-1:0] ts_count;

  trap_timestamp_counter #(.TS_WIDTH(TS_WIDTH)) u_ts (
    .clk_i   (clk),
    .rst_ni  (reset),
    .count_o (ts_count)
  );

  peak_state_e                        state_q, state_d;
  logic signed [SIZE_FILTER_DATA-1:0] x_q, max_q, max_d, amp_q, amp_d;
  logic        [TS_WIDTH-1:0]         x_ts_q, max_ts_q, max_ts_d, time_q, time_d;
  logic        [PEAK_WIDTH_W-1:0]     width_q, width_d, pwidth_q, pwidth_d;
  logic        [PEAK_WIDTH_W-1:0]     dead_q, dead_d;
  logic                               valid_q, valid_d;
  logic                               over;

`ifdef PEAK_PILEUP_REJECT_EN
  logic [PILEUP_COUNT_W-1:0] pileup_q, pileup_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pileup_q <= '0;
    else        pileup_q <= pileup_d;
  end

  assign pileup_count = pileup_q;
`else
  assign pileup_count = '0;
`endif

  assign over = (x_q > THR_S);

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    max_ts_d = max_ts_q;
    width_d  = width_q;
    dead_d   = dead_q;
    valid_d  = 1'b0;
    amp_d    = amp_q;
    time_d   = time_q;
    pwidth_d = pwidth_q;
`ifdef PEAK_PILEUP_REJECT_EN
    pileup_d = pileup_q;
`endif
    case (state_q)
      IDLE: begin
        if (over) begin
          state_d  = ARMED;
          max_d    = x_q;
          max_ts_d = x_ts_q;
          width_d  = PEAK_WIDTH_W'(1);
        end
      end
      ARMED: begin
        if (over) begin
          if (width_q != MAX_W) width_d = width_q + PEAK_WIDTH_W'(1);
          // strict compare keeps the first sample of a flat top
          if (x_q > max_q) begin
            max_d    = x_q;
            max_ts_d = x_ts_q;
          end
`ifdef PEAK_PILEUP_REJECT_EN
          if (width_q == MAX_W) begin
            state_d = REJECT;
            if (pileup_q != '1) pileup_d = pileup_q + PILEUP_COUNT_W'(1);
          end
`endif
        end else begin
          valid_d  = 1'b1;
          amp_d    = max_q;
          time_d   = max_ts_q;
          pwidth_d = width_q;
          dead_d   = DEAD_LOAD;
          if (HOLDOFF == 0) state_d = IDLE;
          else              state_d = DEAD;
        end
      end
      DEAD: begin
        if (dead_q == '0) state_d = IDLE;
        else              dead_d  = dead_q - PEAK_WIDTH_W'(1);
      end
`ifdef PEAK_PILEUP_REJECT_EN
      REJECT: begin
        if (!over) begin
          dead_d = DEAD_LOAD;
          if (HOLDOFF == 0) state_d = IDLE;
          else              state_d = DEAD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      x_ts_q   <= '0;
      max_q    <= '0;
      max_ts_q <= '0;
      width_q  <= '0;
      dead_q   <= '0;
      valid_q  <= 1'b0;
      amp_q    <= '0;
      time_q   <= '0;
      pwidth_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= filter_data;
      x_ts_q   <= ts_count;
      max_q    <= max_d;
      max_ts_q <= max_ts_d;
      width_q  <= width_d;
      dead_q   <= dead_d;
      valid_q  <= valid_d;
      amp_q    <= amp_d;
      time_q   <= time_d;
      pwidth_q <= pwidth_d;
    end
  end

  assign peak_valid = valid_q;
  assign peak_amp   = amp_q;
  assign peak_time  = time_q;
  assign peak_width = pwidth_q;
  assign busy       = (state_q != IDLE);

endmodule
